// File: rtl/rgb_led_pkg.sv
// Shared definitions for the rgb_led_pwm block: register map, control-bit
// positions, duty type and the 8x8 fractional scaling helper.
package rgb_led_pkg;

    typedef logic [7:0] duty_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [1:0] ADDR_DUTY_R = 2'd0;
    localparam logic [1:0] ADDR_DUTY_G = 2'd1;
    localparam logic [1:0] ADDR_DUTY_B = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_BR_R = 1;
    localparam int CTRL_BR_G = 2;
    localparam int CTRL_BR_B = 3;

    // (a * b) >> 8 on 8-bit operands, keeping the top byte of the 16-bit product
    function automatic duty_t scale8(input duty_t a, input duty_t b);
        logic [15:0] prod;
        prod = {8'd0, a} * {8'd0, b};
        return prod[15:8];
    endfunction

endpackage

// File: rtl/rgb_led_pwm_channel.sv
// One PWM output channel: shadow duty register, optional breathe scaling,
// optional square-law gamma (RGB_LED_GAMMA_EN), compare and output flop.
module pwm_channel
    import rgb_led_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  run,
    input  logic  breathe,
    input  duty_t duty_in,
    input  duty_t level,
    input  duty_t pwm_cnt,
    output logic  led_n
);

    duty_t shadow_q, shadow_d;
    logic  led_n_q, led_n_d;
    duty_t br_s;
    duty_t eff_s;

    // Shadow duty picks up the register value only at period boundaries
    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = duty_in;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Effective duty: breathe envelope first, then optional perceptual correction
    always_comb begin
        br_s = shadow_q;
        if (breathe) begin
            br_s = scale8(shadow_q, level);
        end else begin
            br_s = shadow_q;
        end
`ifdef RGB_LED_GAMMA_EN
        eff_s = scale8(br_s, br_s);
`else
        eff_s = br_s;
`endif
    end

    // Pin is driven low while the counter is below the effective duty
    always_comb begin
        led_n_d = 1'b1;
        if (run && (pwm_cnt < eff_s)) begin
            led_n_d = 1'b0;
        end else begin
            led_n_d = 1'b1;
        end
    end

    // Channel state flops with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= 8'd0;
            led_n_q  <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            led_n_q  <= led_n_d;
        end
    end

    assign led_n = led_n_q;

endmodule

// File: rtl/rgb_led_pwm.sv
// Memory-mapped RGB LED PWM driver: register file, prescaler, 8-bit PWM
// counter, breathe level generator and three pwm_channel instances.
// Optional macro RGB_LED_GAMMA_EN enables square-law duty correction.
// The cycle in which enable is first seen is a restart cycle: it raises the
// period boundary and loads the shadows while the counters stay at zero, so
// the first real period starts cleanly on the following cycle.
module rgb_led_pwm
    import rgb_led_pkg::*;
#(
    parameter int unsigned PRESCALE    = 188,
    parameter int unsigned BREATH_STEP = 16
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       led_r_n,
    output logic       led_g_n,
    output logic       led_b_n,
    output logic       period_start
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BW = (BREATH_STEP > 1) ? $clog2(BREATH_STEP) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BDIV_MAX  = BW'(BREATH_STEP - 1);

    duty_t         duty_r_q, duty_r_d;
    duty_t         duty_g_q, duty_g_d;
    duty_t         duty_b_q, duty_b_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [PW-1:0] presc_q, presc_d;
    duty_t         pwm_cnt_q, pwm_cnt_d;
    logic [BW-1:0] bdiv_q, bdiv_d;
    duty_t         level_q, level_d;
    dir_e          dir_q, dir_d;
    logic          en_prev_q, en_prev_d;
    logic          period_start_q, period_start_d;

    logic en_s, start_s, run_s, tick_s, wrap_s, ps_s, bstep_s;
    logic unused_wr_hi_s;

    assign unused_wr_hi_s = ^wr_data[7:4];

    assign en_s    = ctrl_q[CTRL_EN];
    assign start_s = en_s & ~en_prev_q;
    assign run_s   = en_s & en_prev_q;
    assign tick_s  = run_s & (presc_q == PRESC_MAX);
    assign wrap_s  = tick_s & (pwm_cnt_q == 8'hFF);
    assign ps_s    = start_s | wrap_s;
    assign bstep_s = wrap_s & (bdiv_q == BDIV_MAX);

    // Register file writes; control upper nibble is not stored
    always_comb begin
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        ctrl_d   = ctrl_q;
        if (wr_en) begin
            case (addr)
                ADDR_DUTY_R: duty_r_d = wr_data;
                ADDR_DUTY_G: duty_g_d = wr_data;
                ADDR_DUTY_B: duty_b_d = wr_data;
                ADDR_CTRL:   ctrl_d   = wr_data[3:0];
                default:     ctrl_d   = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Readback mux feeding the registered rd_data
    always_comb begin
        rd_data_d = 8'd0;
        case (addr)
            ADDR_DUTY_R: rd_data_d = duty_r_q;
            ADDR_DUTY_G: rd_data_d = duty_g_q;
            ADDR_DUTY_B: rd_data_d = duty_b_q;
            ADDR_CTRL:   rd_data_d = {4'd0, ctrl_q};
            default:     rd_data_d = 8'd0;
        endcase
    end

    // Prescaler, PWM counter and breathe divider; all held at zero while disabled
    always_comb begin
        presc_d   = presc_q;
        pwm_cnt_d = pwm_cnt_q;
        bdiv_d    = bdiv_q;
        en_prev_d = en_s;
        if (!en_s) begin
            presc_d   = '0;
            pwm_cnt_d = 8'd0;
            bdiv_d    = '0;
        end else if (run_s) begin
            if (tick_s) begin
                presc_d   = '0;
                pwm_cnt_d = pwm_cnt_q + 8'd1;
            end else begin
                presc_d   = presc_q + PW'(1);
                pwm_cnt_d = pwm_cnt_q;
            end
            if (wrap_s) begin
                bdiv_d = bstep_s ? '0 : (bdiv_q + BW'(1));
            end else begin
                bdiv_d = bdiv_q;
            end
        end else begin
            presc_d   = '0;
            pwm_cnt_d = 8'd0;
            bdiv_d    = '0;
        end
    end

    // Breathe level triangle 0..255..0 without repeating the endpoints
    always_comb begin
        level_d = level_q;
        dir_d   = dir_q;
        if (!en_s) begin
            level_d = 8'd0;
            dir_d   = DIR_UP;
        end else if (bstep_s) begin
            if (dir_q == DIR_UP) begin
                level_d = level_q + 8'd1;
                dir_d   = (level_q == 8'd254) ? DIR_DOWN : DIR_UP;
            end else begin
                level_d = level_q - 8'd1;
                dir_d   = (level_q == 8'd1) ? DIR_UP : DIR_DOWN;
            end
        end else begin
            level_d = level_q;
            dir_d   = dir_q;
        end
    end

    assign period_start_d = ps_s;

    // Top-level state flops with synchronous reset
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            duty_r_q       <= 8'd0;
            duty_g_q       <= 8'd0;
            duty_b_q       <= 8'd0;
            ctrl_q         <= 4'd0;
            rd_data_q      <= 8'd0;
            presc_q        <= '0;
            pwm_cnt_q      <= 8'd0;
            bdiv_q         <= '0;
            level_q        <= 8'd0;
            dir_q          <= DIR_UP;
            en_prev_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            duty_r_q       <= duty_r_d;
            duty_g_q       <= duty_g_d;
            duty_b_q       <= duty_b_d;
            ctrl_q         <= ctrl_d;
            rd_data_q      <= rd_data_d;
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            bdiv_q         <= bdiv_d;
            level_q        <= level_d;
            dir_q          <= dir_d;
            en_prev_q      <= en_prev_d;
            period_start_q <= period_start_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign period_start = period_start_q;

    pwm_channel u_ch_r (
        .clk     (clk_48mhz),
        .reset   (reset),
        .load    (ps_s),
        .run     (run_s),
        .breathe (ctrl_q[CTRL_BR_R]),
        .duty_in (duty_r_q),
        .level   (level_q),
        .pwm_cnt (pwm_cnt_q),
        .led_n   (led_r_n)
    );

    pwm_channel u_ch_g (
        .clk     (clk_48mhz),
        .reset   (reset),
        .load    (ps_s),
        .run     (run_s),
        .breathe (ctrl_q[CTRL_BR_G]),
        .duty_in (duty_g_q),
        .level   (level_q),
        .pwm_cnt (pwm_cnt_q),
        .led_n   (led_g_n)
    );

    pwm_channel u_ch_b (
        .clk     (clk_48mhz),
        .reset   (reset),
        .load    (ps_s),
        .run     (run_s),
        .breathe (ctrl_q[CTRL_BR_B]),
        .duty_in (duty_b_q),
        .level   (level_q),
        .pwm_cnt (pwm_cnt_q),
        .led_n   (led_b_n)
    );

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Self-checking bench for rgb_led_pwm with PRESCALE = 2, BREATH_STEP = 1.
// A PWM period is 512 clocks; each measurement window is the 512 clocks that
// follow a sampled period_start pulse.
module tb_rgb_led_pwm;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [1:0] addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       led_r_n, led_g_n, led_b_n;
    logic       period_start;

    int total;
    int bad;

    typedef struct {
        logic [7:0] r, g, b;
        int         er, eg, eb;
    } vec_t;

    vec_t vecs [5];

    rgb_led_pwm #(.PRESCALE(2), .BREATH_STEP(1)) dut (
        .clk_48mhz    (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .led_r_n      (led_r_n),
        .led_g_n      (led_g_n),
        .led_b_n      (led_b_n),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lit steps for a given effective duty, with optional square law
    function automatic int gam(input int d);
`ifdef RGB_LED_GAMMA_EN
        return (d * d) >> 8;
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        wr_data = d;
        wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output int v);
        addr = a;
        cyc();
        v = int'(rd_data);
    endtask

    task automatic wait_ps();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (period_start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL ps_timeout: got no period_start expected one within 2000 cycles");
        end
    endtask

    // One PWM window; optional single write issued at index wr_at
    task automatic measure(input int wr_at, input logic [1:0] wa, input logic [7:0] wd,
                           output int lr, output int lg, output int lb,
                           output int psn, output int pslast);
        lr = 0; lg = 0; lb = 0; psn = 0; pslast = -1;
        for (int i = 0; i < 512; i++) begin
            cyc();
            wr_en = 1'b0;
            if (!led_r_n) lr++;
            if (!led_g_n) lg++;
            if (!led_b_n) lb++;
            if (period_start) begin
                psn++;
                pslast = i;
            end
            if (i == wr_at) begin
                addr = wa;
                wr_data = wd;
                wr_en = 1'b1;
            end
        end
    endtask

    initial begin
        int v, lr, lg, lb, psn, pslast, cnt, lows;
        total = 0;
        bad = 0;
        reset = 1'b1;
        wr_en = 1'b0;
        addr = 2'd0;
        wr_data = 8'd0;

        vecs[0] = '{r: 8'd64,  g: 8'd0,   b: 8'd0,   er: 128, eg: 0,   eb: 0};
        vecs[1] = '{r: 8'd0,   g: 8'd255, b: 8'd1,   er: 0,   eg: 510, eb: 2};
        vecs[2] = '{r: 8'd128, g: 8'd200, b: 8'd255, er: 256, eg: 400, eb: 510};
        vecs[3] = '{r: 8'd16,  g: 8'd2,   b: 8'd3,   er: 32,  eg: 4,   eb: 6};
        vecs[4] = '{r: 8'd255, g: 8'd255, b: 8'd255, er: 510, eg: 510, eb: 510};
`ifdef RGB_LED_GAMMA_EN
        for (int i = 0; i < 5; i++) begin
            vecs[i].er = 2 * gam(int'(vecs[i].r));
            vecs[i].eg = 2 * gam(int'(vecs[i].g));
            vecs[i].eb = 2 * gam(int'(vecs[i].b));
        end
`endif

        // Reset state
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_led_r", int'(led_r_n), 1);
        check("rst_led_g", int'(led_g_n), 1);
        check("rst_led_b", int'(led_b_n), 1);
        check("rst_rd_data", int'(rd_data), 0);
        cnt = 0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (period_start) cnt++;
            if (!led_r_n || !led_g_n || !led_b_n) lows++;
        end
        check("rst_no_ps", cnt, 0);
        check("rst_leds_off", lows, 0);

        // Register readback, control upper nibble reads zero
        wr(ADDR_DUTY_R_C(), 8'h11);
        rd(2'd0, v); check("rb_r", v, 8'h11);
        wr(2'd1, 8'h22);
        rd(2'd1, v); check("rb_g", v, 8'h22);
        wr(2'd2, 8'h33);
        rd(2'd2, v); check("rb_b", v, 8'h33);
        wr(2'd3, 8'hFE);
        rd(2'd3, v); check("rb_ctrl", v, 8'h0E);
        wr(2'd3, 8'h00);

        // Table-driven steady duty vectors
        for (int i = 0; i < 5; i++) begin
            wr(2'd3, 8'h00);
            wr(2'd0, vecs[i].r);
            wr(2'd1, vecs[i].g);
            wr(2'd2, vecs[i].b);
            wr(2'd3, 8'h01);
            wait_ps();
            measure(-1, 2'd0, 8'd0, lr, lg, lb, psn, pslast);
            check($sformatf("vec%0d_r", i), lr, vecs[i].er);
            check($sformatf("vec%0d_g", i), lg, vecs[i].eg);
            check($sformatf("vec%0d_b", i), lb, vecs[i].eb);
            check($sformatf("vec%0d_ps_count", i), psn, 1);
            check($sformatf("vec%0d_ps_period", i), pslast, 511);
        end

        // Glitch-free update: mid-period write and write on the wrap cycle
        wr(2'd3, 8'h00);
        wr(2'd0, 8'd64);
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd0);
        wr(2'd3, 8'h01);
        wait_ps();
        measure(200, 2'd0, 8'd200, lr, lg, lb, psn, pslast);
        check("glitch_cur_period", lr, 2 * gam(64));
        measure(-1, 2'd0, 8'd0, lr, lg, lb, psn, pslast);
        check("glitch_next_period", lr, 2 * gam(200));
        measure(510, 2'd0, 8'd10, lr, lg, lb, psn, pslast);
        check("wrap_wr_cur", lr, 2 * gam(200));
        measure(-1, 2'd0, 8'd0, lr, lg, lb, psn, pslast);
        check("wrap_wr_deferred", lr, 2 * gam(200));
        measure(-1, 2'd0, 8'd0, lr, lg, lb, psn, pslast);
        check("wrap_wr_applied", lr, 2 * gam(10));

        // Disable mid-period, then clean restart
        wr(2'd0, 8'd64);
        wait_ps();
        measure(-1, 2'd0, 8'd0, lr, lg, lb, psn, pslast);
        for (int i = 0; i < 20; i++) cyc();
`ifndef RGB_LED_GAMMA_EN
        check("dis_pre_lit", int'(led_r_n), 0);
`endif
        wr(2'd3, 8'h00);
        cyc();
        check("dis_led_off", int'(led_r_n), 1);
        cnt = 0;
        lows = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc();
            if (period_start) cnt++;
            if (!led_r_n) lows++;
        end
        check("dis_no_ps", cnt, 0);
        check("dis_no_lit", lows, 0);
        wr(2'd3, 8'h01);
        cyc();
        check("reen_first_ps", int'(period_start), 1);
        measure(-1, 2'd0, 8'd0, lr, lg, lb, psn, pslast);
        check("reen_r", lr, 2 * gam(64));
        check("reen_ps_period", pslast, 511);

        // Breathe on B with level stepping every period
        wr(2'd3, 8'h00);
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd255);
        wr(2'd3, 8'h09);
        wait_ps();
        for (int k = 0; k < 130; k++) begin
            measure(-1, 2'd0, 8'd0, lr, lg, lb, psn, pslast);
            if (k <= 5 || k >= 127) begin
                check($sformatf("breathe_b_lvl%0d", k), lb, 2 * gam((255 * k) >> 8));
                check($sformatf("breathe_r_lvl%0d", k), lr, 0);
            end
        end

        // Mid-run reset with a write strobe held high
        wr(2'd0, 8'd200);
        for (int i = 0; i < 30; i++) cyc();
        reset = 1'b1;
        addr = 2'd0;
        wr_data = 8'hAA;
        wr_en = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        wr_en = 1'b0;
        check("mrst_led_r", int'(led_r_n), 1);
        check("mrst_led_b", int'(led_b_n), 1);
        check("mrst_ps", int'(period_start), 0);
        check("mrst_rd", int'(rd_data), 0);
        rd(2'd0, v); check("mrst_reg_r", v, 0);
        rd(2'd2, v); check("mrst_reg_b", v, 0);
        rd(2'd3, v); check("mrst_reg_ctrl", v, 0);
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (period_start || !led_b_n) cnt++;
        end
        check("mrst_idle", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [1:0] ADDR_DUTY_R_C();
        return 2'd0;
    endfunction

endmodule
